// File: rtl/xbar_rr_arbiter_if.sv
// Handshake and grant bundle between one crossbar output port and its arbiter.
interface xbar_rr_arbiter_if;
  logic [15:0] request;
  logic        last;
  logic        ready;
  logic [15:0] grant;
  logic [3:0]  sel;
  logic        valid;
  logic [7:0]  beat_cnt;

  modport master (
    output request, last, ready,
    input  grant, sel, valid, beat_cnt
  );

  modport slave (
    input  request, last, ready,
    output grant, sel, valid, beat_cnt
  );
endinterface

// File: rtl/xbar_rr_arbiter.sv
// Round-robin arbiter for one 16-input crossbar output port; all outputs registered.
// A grant holds for a burst until last, the MAX_BURST beat cap, or withdrawal of the granted request.
module xbar_rr_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst,
  xbar_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [15:0] grant_q, grant_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        valid_q, valid_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [8:0]  cnt_inc;
  logic [3:0]  arb_ptr;
  logic        arb_found;
  logic [3:0]  arb_idx;
  logic        rel;

  // In BUSY the pointer is only consulted on release, where it becomes sel+1.
  assign arb_ptr = (state_q == BUSY) ? sel_q + 4'd1 : ptr_q;

  // Descending scan so the bit closest to arb_ptr (in wrap order) wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (bus.request[arb_ptr + 4'(k)]) begin
        arb_found = 1'b1;
        arb_idx   = arb_ptr + 4'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    cnt_inc = {1'b0, cnt_q} + 9'd1;
    rel     = 1'b0;

    if (state_q == BUSY) begin
      if (!bus.request[sel_q]) begin
        rel = 1'b1;
      end else if (valid_q && bus.ready) begin
        if (bus.last || cnt_inc == 9'(MAX_BURST)) rel = 1'b1;
        else                                      cnt_d = cnt_inc[7:0];
      end
    end

    if (rel) ptr_d = sel_q + 4'd1;

    if (state_q == IDLE || rel) begin
      cnt_d = 8'd0;
      if (arb_found) begin
        state_d = BUSY;
        grant_d = 16'h0001 << arb_idx;
        sel_d   = arb_idx;
        valid_d = 1'b1;
      end else begin
        state_d = IDLE;
        grant_d = 16'h0000;
        sel_d   = 4'd0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 16'h0000;
      sel_q   <= 4'd0;
      valid_q <= 1'b0;
      cnt_q   <= 8'd0;
      ptr_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.sel      = sel_q;
  assign bus.valid    = valid_q;
  assign bus.beat_cnt = cnt_q;
endmodule

// File: tb/tb_xbar_rr_arbiter.sv
// Directed scenarios for xbar_rr_arbiter; expectations are queued per cycle and checked by a negedge monitor.
module tb_xbar_rr_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  xbar_rr_arbiter_if bus ();

  xbar_rr_arbiter #(.MAX_BURST(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] g;
    logic [3:0]  s;
    logic [7:0]  c;
  } exp_t;

  exp_t  sb[$];
  string sb_nm[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic expect_next(input logic [15:0] g, input logic [3:0] s, input logic [7:0] c,
                             input string nm);
    exp_t e;
    e.cyc = cyc + 1;
    e.g   = g;
    e.s   = s;
    e.c   = c;
    sb.push_back(e);
    sb_nm.push_back(nm);
  endtask

  // Apply inputs for the coming edge and queue the outputs expected after it.
  task automatic drive(input logic [15:0] req, input logic lst, input logic rdy,
                       input logic [15:0] g, input logic [3:0] s, input logic [7:0] c,
                       input string nm);
    @(posedge clk);
    #1;
    bus.request = req;
    bus.last    = lst;
    bus.ready   = rdy;
    expect_next(g, s, c, nm);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst         = 1'b1;
    bus.request = 16'h0000;
    bus.last    = 1'b0;
    bus.ready   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string nm;
    chk("onehot0", 32'($onehot0(bus.grant)), 32'd1);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e  = sb.pop_front();
      nm = sb_nm.pop_front();
      if (e.cyc != cyc) begin
        chk({nm, ".missed_cycle"}, 32'(cyc), 32'(e.cyc));
      end else begin
        chk({nm, ".grant"},    32'(bus.grant),    32'(e.g));
        chk({nm, ".sel"},      32'(bus.sel),      32'(e.s));
        chk({nm, ".valid"},    32'(bus.valid),    32'(|e.g));
        chk({nm, ".beat_cnt"}, 32'(bus.beat_cnt), 32'(e.c));
      end
    end
  end

  initial begin
    rst         = 1'b1;
    bus.request = 16'h0000;
    bus.last    = 1'b0;
    bus.ready   = 1'b0;
    @(posedge clk);
    #1;
    chk("rst.grant",    32'(bus.grant),    32'd0);
    chk("rst.sel",      32'(bus.sel),      32'd0);
    chk("rst.valid",    32'(bus.valid),    32'd0);
    chk("rst.beat_cnt", 32'(bus.beat_cnt), 32'd0);
    rst = 1'b0;
    drive(16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 8'd0, "idle");

    // Single burst on input 0, last on the third beat while request drops.
    drive(16'h0001, 1'b0, 1'b1, 16'h0001, 4'd0, 8'd0, "t1_grant");
    drive(16'h0001, 1'b0, 1'b1, 16'h0001, 4'd0, 8'd1, "t1_beat1");
    drive(16'h0001, 1'b0, 1'b1, 16'h0001, 4'd0, 8'd2, "t1_beat2");
    drive(16'h0000, 1'b1, 1'b1, 16'h0000, 4'd0, 8'd0, "t1_release");
    drive(16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 8'd0, "t1_idle");

    // Three-way contention, single-beat bursts.
    reset_dut();
    drive(16'h0007, 1'b1, 1'b1, 16'h0001, 4'd0, 8'd0, "t2_s0");
    drive(16'h0007, 1'b1, 1'b1, 16'h0002, 4'd1, 8'd0, "t2_s1");
    drive(16'h0007, 1'b1, 1'b1, 16'h0004, 4'd2, 8'd0, "t2_s2");
    drive(16'h0007, 1'b1, 1'b1, 16'h0001, 4'd0, 8'd0, "t2_s0b");
    drive(16'h0007, 1'b1, 1'b1, 16'h0002, 4'd1, 8'd0, "t2_s1b");
    drive(16'h0000, 1'b1, 1'b1, 16'h0000, 4'd0, 8'd0, "t2_idle");

    // All sixteen requesting: sel walks 0..15 then wraps to 0.
    reset_dut();
    for (int i = 0; i < 17; i++)
      drive(16'hFFFF, 1'b1, 1'b1, 16'h0001 << (i % 16), 4'(i % 16), 8'd0, "t3_walk");
    drive(16'h0000, 1'b1, 1'b1, 16'h0000, 4'd0, 8'd0, "t3_idle");

    // Burst cap with ready toggling: release after the 8th transfer, re-grant input 2.
    reset_dut();
    drive(16'h0004, 1'b0, 1'b0, 16'h0004, 4'd2, 8'd0, "t4_grant");
    for (int k = 1; k <= 8; k++) begin
      drive(16'h0004, 1'b0, 1'b1, 16'h0004, 4'd2, (k < 8) ? 8'(k) : 8'd0, "t4_beat");
      if (k < 8) drive(16'h0004, 1'b0, 1'b0, 16'h0004, 4'd2, 8'(k), "t4_stall");
    end
    drive(16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 8'd0, "t4_idle");

    // Withdrawal: move ptr to 4, grant input 4, then it drops request while stalled.
    reset_dut();
    drive(16'h0008, 1'b1, 1'b0, 16'h0008, 4'd3, 8'd0, "t5_grant3");
    drive(16'h0038, 1'b1, 1'b1, 16'h0010, 4'd4, 8'd0, "t5_grant4");
    drive(16'h0030, 1'b0, 1'b0, 16'h0010, 4'd4, 8'd0, "t5_stall");
    drive(16'h0020, 1'b0, 1'b0, 16'h0020, 4'd5, 8'd0, "t5_withdraw");
    drive(16'h0020, 1'b0, 1'b1, 16'h0020, 4'd5, 8'd1, "t5_beat");
    drive(16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 8'd0, "t5_idle");

    // Asynchronous reset in the middle of a burst on input 8.
    reset_dut();
    drive(16'h0100, 1'b0, 1'b1, 16'h0100, 4'd8, 8'd0, "t6_grant");
    drive(16'h0100, 1'b0, 1'b1, 16'h0100, 4'd8, 8'd1, "t6_beat");
    @(posedge clk);
    @(negedge clk);
    #1;
    rst         = 1'b1;
    bus.request = 16'h0101;
    #1;
    chk("t6_async.grant",    32'(bus.grant),    32'd0);
    chk("t6_async.sel",      32'(bus.sel),      32'd0);
    chk("t6_async.valid",    32'(bus.valid),    32'd0);
    chk("t6_async.beat_cnt", 32'(bus.beat_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_next(16'h0001, 4'd0, 8'd0, "t6_after_rst");
    drive(16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 8'd0, "t6_idle");

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
